number_bank: RTL and testbench

NUMBER_BANK -- requirements
Module: number_bank

---
 rtl/number_bank.sv | 102 ++++++++++
 tb/tb_number_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/number_bank.sv
// Bank of NCH small constant channels, each counting per its own mode on tick.
// Writes load value/mode/lock unless the channel is locked; rdata/rwrap give a registered read port.
module number_bank #(
  parameter int unsigned       WIDTH = 3,
  parameter int unsigned       NCH   = 4,
  parameter int unsigned       AW    = 2,
  parameter logic [WIDTH-1:0]  INIT  = {WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [1:0]           wmode,
  input  logic                 wlock,
  input  logic                 tick,
  input  logic [AW-1:0]        raddr,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rwrap,
  output logic [NCH*WIDTH-1:0] A,
  output logic                 werr
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;
  localparam logic [1:0] MODE_ROTL = 2'b11;

  logic [WIDTH-1:0] val_q  [NCH];
  logic [WIDTH-1:0] val_d  [NCH];
  logic [1:0]       mode_q [NCH];
  logic [1:0]       mode_d [NCH];
  logic             lock_q [NCH];
  logic             lock_d [NCH];
  logic             wrap_q [NCH];
  logic             wrap_d [NCH];

  // Shift-or form keeps WIDTH=1 legal: the rotate collapses to the identity.
  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return WIDTH'((v << 1) | (v >> (WIDTH - 1)));
  endfunction

  // Next state per channel: an accepted write wins over tick.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      val_d[i]  = val_q[i];
      mode_d[i] = mode_q[i];
      lock_d[i] = lock_q[i];
      wrap_d[i] = wrap_q[i];
      if (we && (waddr == AW'(i)) && !lock_q[i]) begin
        val_d[i]  = wdata;
        mode_d[i] = wmode;
        lock_d[i] = wlock;
        wrap_d[i] = 1'b0;
      end else if (tick) begin
        case (mode_q[i])
          MODE_INC: begin
            val_d[i] = val_q[i] + WIDTH'(1);
            if (val_q[i] == {WIDTH{1'b1}}) wrap_d[i] = 1'b1;
          end
          MODE_DEC: begin
            val_d[i] = val_q[i] - WIDTH'(1);
            if (val_q[i] == '0) wrap_d[i] = 1'b1;
          end
          MODE_ROTL: val_d[i] = rotl1(val_q[i]);
          MODE_HOLD: val_d[i] = val_q[i];
          default:   val_d[i] = val_q[i];
        endcase
      end
    end
  end

  // Channel state and read port; the read port captures the post-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        val_q[i]  <= INIT;
        mode_q[i] <= MODE_HOLD;
        lock_q[i] <= 1'b0;
        wrap_q[i] <= 1'b0;
      end
      rdata <= INIT;
      rwrap <= 1'b0;
      werr  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        val_q[i]  <= val_d[i];
        mode_q[i] <= mode_d[i];
        lock_q[i] <= lock_d[i];
        wrap_q[i] <= wrap_d[i];
      end
      rdata <= val_d[raddr];
      rwrap <= wrap_d[raddr];
      werr  <= we && lock_q[waddr];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign A[g*WIDTH +: WIDTH] = val_q[g];
  end

endmodule

// File: tb/tb_number_bank.sv
// Randomized and directed bench for number_bank (WIDTH=3, NCH=4) against a
// behavioural channel model; directed literals pin the model itself.
module tb_number_bank;

  localparam int unsigned W   = 3;
  localparam int unsigned N   = 4;
  localparam int          MOD = 8;

  logic         clk;
  logic         rst;
  logic         we;
  logic [1:0]   waddr;
  logic [2:0]   wdata;
  logic [1:0]   wmode;
  logic         wlock;
  logic         tick;
  logic [1:0]   raddr;
  logic [2:0]   rdata;
  logic         rwrap;
  logic [11:0]  a_w;
  logic         werr;

  number_bank #(.WIDTH(W), .NCH(N), .AW(2), .INIT(3'b111)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wmode(wmode), .wlock(wlock), .tick(tick), .raddr(raddr),
    .rdata(rdata), .rwrap(rwrap), .A(a_w), .werr(werr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer channel records.
  int m_val  [N];
  int m_mode [N];
  int m_lock [N];
  int m_wrap [N];
  int m_rdata, m_rwrap, m_werr;
  bit started = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_val[i] = 7; m_mode[i] = 0; m_lock[i] = 0; m_wrap[i] = 0;
      end
      m_rdata = 7; m_rwrap = 0; m_werr = 0;
      started = 1;
    end else if (started) begin
      m_werr = (we && m_lock[waddr] != 0) ? 1 : 0;
      for (int i = 0; i < N; i++) begin
        if (we && int'(waddr) == i && m_lock[i] == 0) begin
          m_val[i] = int'(wdata); m_mode[i] = int'(wmode);
          m_lock[i] = int'(wlock); m_wrap[i] = 0;
        end else if (tick) begin
          case (m_mode[i])
            1: begin
              if (m_val[i] == MOD - 1) m_wrap[i] = 1;
              m_val[i] = (m_val[i] + 1) % MOD;
            end
            2: begin
              if (m_val[i] == 0) m_wrap[i] = 1;
              m_val[i] = (m_val[i] + MOD - 1) % MOD;
            end
            3: m_val[i] = (m_val[i] * 2) % MOD + m_val[i] / (MOD / 2);
            default: ;
          endcase
        end
      end
      m_rdata = m_val[raddr];
      m_rwrap = m_wrap[raddr];
    end
    #1;
    if (started) begin
      int exp_a;
      exp_a = 0;
      for (int i = 0; i < N; i++) exp_a += m_val[i] * (1 << (i * W));
      chk("model_A", 32'(a_w), 32'(exp_a));
      chk("model_rdata", 32'(rdata), 32'(m_rdata));
      chk("model_rwrap", 32'(rwrap), 32'(m_rwrap));
      chk("model_werr", 32'(werr), 32'(m_werr));
    end
  end

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic cyc(input logic r, input logic w, input logic [1:0] wa,
                     input logic [2:0] wd, input logic [1:0] wm, input logic wl,
                     input logic t, input logic [1:0] ra);
    rst = r; we = w; waddr = wa; wdata = wd; wmode = wm; wlock = wl;
    tick = t; raddr = ra;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wmode = '0;
    wlock = 1'b0; tick = 1'b0; raddr = '0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset then idle: every channel reads INIT.
    for (int r = 0; r < 4; r++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 2'(r));
      chk("idle_A", 32'(a_w), 32'h0FFF);
      chk("idle_rdata", 32'(rdata), 32'd7);
      chk("idle_werr", 32'(werr), 32'd0);
    end

    // ch1 INC from 6 across the wrap.
    cyc(0, 1, 1, 3'd6, 2'b01, 0, 0, 1);
    chk("inc_load", 32'(rdata), 32'd6);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("inc_t1", 32'({rwrap, rdata}), 32'({1'b0, 3'd7}));
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("inc_t2", 32'({rwrap, rdata}), 32'({1'b1, 3'd0}));
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("inc_t3", 32'({rwrap, rdata}), 32'({1'b1, 3'd1}));
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("inc_sticky", 32'(rwrap), 32'd1);
    cyc(0, 1, 1, 3'd0, 2'b00, 0, 0, 1);
    chk("inc_rewrite", 32'({rwrap, rdata}), 32'({1'b0, 3'd0}));

    // ch2 locked ROTL from 3; later write rejected.
    cyc(0, 1, 2, 3'd3, 2'b11, 1, 0, 2);
    chk("rotl_load", 32'(rdata), 32'd3);
    cyc(0, 0, 0, 0, 0, 0, 1, 2);
    chk("rotl_t1", 32'(rdata), 32'd6);
    cyc(0, 0, 0, 0, 0, 0, 1, 2);
    chk("rotl_t2", 32'(rdata), 32'd5);
    cyc(0, 1, 2, 3'd0, 2'b00, 0, 0, 2);
    chk("lock_rdata", 32'(rdata), 32'd5);
    chk("lock_werr", 32'(werr), 32'd1);
    chk("lock_A", 32'(a_w), 32'h0F47);
    cyc(0, 0, 0, 0, 0, 0, 0, 2);
    chk("lock_werr_end", 32'(werr), 32'd0);

    // ch0 DEC written together with tick: write wins, then wraps to 7.
    cyc(0, 1, 0, 3'd0, 2'b10, 0, 1, 0);
    chk("dec_load", 32'({rwrap, rdata}), 32'({1'b0, 3'd0}));
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("dec_wrap", 32'({rwrap, rdata}), 32'({1'b1, 3'd7}));

    // Rejected write with tick on locked ch2: advances and flags.
    cyc(0, 1, 2, 3'd0, 2'b00, 0, 1, 2);
    chk("rej_tick_werr", 32'(werr), 32'd1);

    // Reset mid-count overrides write and tick.
    cyc(0, 1, 1, 3'd2, 2'b01, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("pre_rst", 32'(rdata), 32'd4);
    cyc(1, 1, 1, 3'd5, 2'b01, 0, 1, 1);
    chk("rst_A", 32'(a_w), 32'h0FFF);
    chk("rst_out", 32'({werr, rwrap, rdata}), 32'({1'b0, 1'b0, 3'd7}));
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 2'(k));
      chk("post_rst_A", 32'(a_w), 32'h0FFF);
      chk("post_rst_werr", 32'(werr), 32'd0);
    end

    // Random traffic; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 1) == 1),
          2'($urandom_range(0, 3)));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
